// File: rtl/ss_write_pkg.sv
// ss_write_pkg
//   Shared types and constants for the BRAM range writer.
//   state_t  : controller states (IDLE, RUN, FINISH)
//   DIR_UP   : ascending address traversal
//   DIR_DOWN : descending address traversal
package ss_write_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/ss_rise_detect.sv
// ss_rise_detect
//   Registered rising-edge detector. The history register resets to 1 so a
//   level already high when reset is released is not reported as an edge.
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset
//   i_level : level input to watch
//   o_rise  : high while i_level is 1 and was 0 at the previous clock edge
module ss_rise_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_rise
);

    logic hist_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= i_level;
        end
    end

    assign o_rise = i_level & ~hist_q;

endmodule

// File: rtl/ss_range_write_ctrl.sv
// ss_range_write_ctrl
//   BRAM range writer: on an i_start rising edge writes one word per accepted
//   beat into [si .. ei] (inclusive, modulo 2^SIZE_ADDR), ascending or
//   descending, from a valid/ready source or from a constant fill word.
//   i_clk, i_rst              : clock, asynchronous active-high reset
//   i_start                   : level, rising edge launches a job
//   i_abort                   : abort the running job
//   i_dir, i_fill, i_fill_data: direction, fill mode, fill word (launch)
//   i_si_ram, i_ei_ram        : first / last address (launch)
//   i_valid, i_data, o_ready  : source handshake
//   o_we_ram, o_addr_ram,
//   o_data_ram                : registered BRAM write port
//   o_busy, o_done, o_aborted : status; done/aborted are one-cycle pulses
//   o_count                   : words written in current/last job
module ss_range_write_ctrl
    import ss_write_pkg::*;
#(
    parameter int unsigned SIZE_ADDR = 6,
    parameter int unsigned SIZE_DATA = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_dir,
    input  logic                 i_fill,
    input  logic [SIZE_DATA-1:0] i_fill_data,
    input  logic [SIZE_ADDR-1:0] i_si_ram,
    input  logic [SIZE_ADDR-1:0] i_ei_ram,
    input  logic                 i_valid,
    input  logic [SIZE_DATA-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_we_ram,
    output logic [SIZE_ADDR-1:0] o_addr_ram,
    output logic [SIZE_DATA-1:0] o_data_ram,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_aborted,
    output logic [SIZE_ADDR:0]   o_count
);

    localparam logic [SIZE_ADDR-1:0] ADDR_ONE = SIZE_ADDR'(1);
    localparam logic [SIZE_ADDR:0]   CNT_ONE  = (SIZE_ADDR + 1)'(1);

    state_t                 state_q, state_d;
    logic [SIZE_ADDR-1:0]   cur_q, cur_d;
    logic [SIZE_ADDR-1:0]   ei_q, ei_d;
    logic                   dir_q, dir_d;
    logic                   fill_q, fill_d;
    logic [SIZE_DATA-1:0]   fill_data_q, fill_data_d;
    logic [SIZE_ADDR:0]     cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [SIZE_ADDR-1:0]   addr_q, addr_d;
    logic [SIZE_DATA-1:0]   data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;
    logic                   start_rise;

    ss_rise_detect u_start_edge (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_level (i_start),
        .o_rise  (start_rise)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            ei_q        <= '0;
            dir_q       <= DIR_UP;
            fill_q      <= 1'b0;
            fill_data_q <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            ei_q        <= ei_d;
            dir_q       <= dir_d;
            fill_q      <= fill_d;
            fill_data_q <= fill_data_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        ei_d        = ei_q;
        dir_d       = dir_q;
        fill_d      = fill_q;
        fill_data_d = fill_data_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = '0;
        done_d      = 1'b0;
        aborted_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    cur_d       = i_si_ram;
                    ei_d        = i_ei_ram;
                    dir_d       = i_dir;
                    fill_d      = i_fill;
                    fill_data_d = i_fill_data;
                    cnt_d       = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                // Abort has priority over a beat, including the final one.
                if (i_abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (fill_q || i_valid) begin
                    we_d   = 1'b1;
                    addr_d = cur_q;
                    data_d = fill_q ? fill_data_q : i_data;
                    cnt_d  = cnt_q + CNT_ONE;
                    cur_d  = (dir_q == DIR_DOWN) ? cur_q - ADDR_ONE : cur_q + ADDR_ONE;
                    if (cur_q == ei_q) begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign o_ready    = (state_q == RUN) & ~fill_q & ~i_abort;
    assign o_we_ram   = we_q;
    assign o_addr_ram = addr_q;
    assign o_data_ram = data_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_aborted  = aborted_q;
    assign o_count    = cnt_q;

endmodule

// File: tb/tb_ss_range_write_ctrl.sv
module tb_ss_range_write_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst, i_start, i_abort, i_dir, i_fill, i_valid;
    logic [7:0] i_fill_data, i_data;
    logic [5:0] i_si_ram, i_ei_ram;
    logic       o_ready, o_we_ram, o_busy, o_done, o_aborted;
    logic [5:0] o_addr_ram;
    logic [7:0] o_data_ram;
    logic [6:0] o_count;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    ss_range_write_ctrl #(.SIZE_ADDR(6), .SIZE_DATA(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_dir       (i_dir),
        .i_fill      (i_fill),
        .i_fill_data (i_fill_data),
        .i_si_ram    (i_si_ram),
        .i_ei_ram    (i_ei_ram),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .o_we_ram    (o_we_ram),
        .o_addr_ram  (o_addr_ram),
        .o_data_ram  (o_data_ram),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_aborted   (o_aborted),
        .o_count     (o_count)
    );

    typedef struct {
        logic [5:0] si, ei;
        logic       dir, fill;
        logic [7:0] fd;
        logic       st, ab, vl;
        logic [7:0] d;
        logic       x_rdy, x_we;
        logic [5:0] x_addr;
        logic [7:0] x_data;
        logic       x_busy, x_done, x_abt;
        logic [6:0] x_cnt;
    } vec_t;

    localparam int NV = 29;
    vec_t tbl [NV];

    function automatic vec_t V(input logic [5:0] si, input logic [5:0] ei, input logic dir,
                               input logic fill, input logic [7:0] fd, input logic st,
                               input logic ab, input logic vl, input logic [7:0] d,
                               input logic x_rdy, input logic x_we, input logic [5:0] x_addr,
                               input logic [7:0] x_data, input logic x_busy, input logic x_done,
                               input logic x_abt, input logic [6:0] x_cnt);
        vec_t r;
        r.si = si; r.ei = ei; r.dir = dir; r.fill = fill; r.fd = fd;
        r.st = st; r.ab = ab; r.vl = vl; r.d = d;
        r.x_rdy = x_rdy; r.x_we = x_we; r.x_addr = x_addr; r.x_data = x_data;
        r.x_busy = x_busy; r.x_done = x_done; r.x_abt = x_abt; r.x_cnt = x_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic we, input logic [5:0] addr,
                            input logic [7:0] data, input logic busy, input logic done,
                            input logic abt, input logic [6:0] cnt);
        chk({tag, "_we"},   32'(o_we_ram),   32'(we));
        chk({tag, "_addr"}, 32'(o_addr_ram), 32'(addr));
        chk({tag, "_data"}, 32'(o_data_ram), 32'(data));
        chk({tag, "_busy"}, 32'(o_busy),     32'(busy));
        chk({tag, "_done"}, 32'(o_done),     32'(done));
        chk({tag, "_abt"},  32'(o_aborted),  32'(abt));
        chk({tag, "_cnt"},  32'(o_count),    32'(cnt));
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // ascending stream 4..7
        tbl[0]  = V(4, 7, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0,  8'h00, 0, 0, 0, 0);
        tbl[1]  = V(4, 7, 0, 0, 8'h00, 1, 0, 1, 8'hA0, 0, 0, 0,  8'h00, 1, 0, 0, 0);
        tbl[2]  = V(4, 7, 0, 0, 8'h00, 1, 0, 1, 8'hA0, 1, 1, 4,  8'hA0, 1, 0, 0, 1);
        tbl[3]  = V(4, 7, 0, 0, 8'h00, 1, 0, 1, 8'hA1, 1, 1, 5,  8'hA1, 1, 0, 0, 2);
        tbl[4]  = V(4, 7, 0, 0, 8'h00, 1, 0, 1, 8'hA2, 1, 1, 6,  8'hA2, 1, 0, 0, 3);
        tbl[5]  = V(4, 7, 0, 0, 8'h00, 1, 0, 1, 8'hA3, 1, 1, 7,  8'hA3, 1, 1, 0, 4);
        tbl[6]  = V(4, 7, 0, 0, 8'h00, 0, 0, 1, 8'hFF, 0, 0, 7,  8'h00, 0, 0, 0, 4);
        // ascending wrap 62..1
        tbl[7]  = V(62, 1, 0, 0, 8'h00, 1, 0, 1, 8'h10, 0, 0, 7,  8'h00, 1, 0, 0, 0);
        tbl[8]  = V(62, 1, 0, 0, 8'h00, 1, 0, 1, 8'h10, 1, 1, 62, 8'h10, 1, 0, 0, 1);
        tbl[9]  = V(62, 1, 0, 0, 8'h00, 1, 0, 1, 8'h11, 1, 1, 63, 8'h11, 1, 0, 0, 2);
        tbl[10] = V(62, 1, 0, 0, 8'h00, 1, 0, 1, 8'h12, 1, 1, 0,  8'h12, 1, 0, 0, 3);
        tbl[11] = V(62, 1, 0, 0, 8'h00, 1, 0, 1, 8'h13, 1, 1, 1,  8'h13, 1, 1, 0, 4);
        tbl[12] = V(62, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1,  8'h00, 0, 0, 0, 4);
        // descending wrap 1..62
        tbl[13] = V(1, 62, 1, 0, 8'h00, 1, 0, 1, 8'h20, 0, 0, 1,  8'h00, 1, 0, 0, 0);
        tbl[14] = V(1, 62, 1, 0, 8'h00, 1, 0, 1, 8'h20, 1, 1, 1,  8'h20, 1, 0, 0, 1);
        tbl[15] = V(1, 62, 1, 0, 8'h00, 1, 0, 1, 8'h21, 1, 1, 0,  8'h21, 1, 0, 0, 2);
        tbl[16] = V(1, 62, 1, 0, 8'h00, 1, 0, 1, 8'h22, 1, 1, 63, 8'h22, 1, 0, 0, 3);
        tbl[17] = V(1, 62, 1, 0, 8'h00, 1, 0, 1, 8'h23, 1, 1, 62, 8'h23, 1, 1, 0, 4);
        tbl[18] = V(1, 62, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 62, 8'h00, 0, 0, 0, 4);
        // backpressure 0..2, valid 1,0,0,1,1
        tbl[19] = V(0, 2, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 62, 8'h00, 1, 0, 0, 0);
        tbl[20] = V(0, 2, 0, 0, 8'h00, 1, 0, 1, 8'h30, 1, 1, 0,  8'h30, 1, 0, 0, 1);
        tbl[21] = V(0, 2, 0, 0, 8'h00, 1, 0, 0, 8'h31, 1, 0, 0,  8'h00, 1, 0, 0, 1);
        tbl[22] = V(0, 2, 0, 0, 8'h00, 1, 0, 0, 8'h32, 1, 0, 0,  8'h00, 1, 0, 0, 1);
        tbl[23] = V(0, 2, 0, 0, 8'h00, 1, 0, 1, 8'h33, 1, 1, 1,  8'h33, 1, 0, 0, 2);
        tbl[24] = V(0, 2, 0, 0, 8'h00, 1, 0, 1, 8'h34, 1, 1, 2,  8'h34, 1, 1, 0, 3);
        tbl[25] = V(0, 2, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 2,  8'h00, 0, 0, 0, 3);
        // fill single word at 10
        tbl[26] = V(10, 10, 0, 1, 8'h5A, 1, 0, 0, 8'h00, 0, 0, 2,  8'h00, 1, 0, 0, 0);
        tbl[27] = V(10, 10, 0, 1, 8'h5A, 1, 0, 0, 8'h00, 0, 1, 10, 8'h5A, 1, 1, 0, 1);
        tbl[28] = V(10, 10, 0, 1, 8'h5A, 0, 0, 1, 8'h00, 0, 0, 10, 8'h00, 0, 0, 0, 1);

        i_rst = 1'b1; i_start = 1'b1; i_abort = 1'b0; i_dir = 1'b0; i_fill = 1'b0;
        i_fill_data = '0; i_si_ram = '0; i_ei_ram = '0; i_valid = 1'b0; i_data = '0;

        // reset state, with i_start already high
        repeat (2) @(posedge i_clk);
        #1;
        chk_outs("rst", 0, 0, 8'h00, 0, 0, 0, 0);
        chk("rst_ready", 32'(o_ready), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("held_start_busy%0d", i), 32'(o_busy), 0);
        end
        i_start = 1'b0;
        tick();

        // table-driven sequences
        for (int i = 0; i < NV; i++) begin
            i_si_ram = tbl[i].si; i_ei_ram = tbl[i].ei; i_dir = tbl[i].dir;
            i_fill = tbl[i].fill; i_fill_data = tbl[i].fd; i_start = tbl[i].st;
            i_abort = tbl[i].ab; i_valid = tbl[i].vl; i_data = tbl[i].d;
            @(negedge i_clk);
            chk($sformatf("v%0d_ready", i), 32'(o_ready), 32'(tbl[i].x_rdy));
            tick();
            chk_outs($sformatf("v%0d", i), tbl[i].x_we, tbl[i].x_addr, tbl[i].x_data,
                     tbl[i].x_busy, tbl[i].x_done, tbl[i].x_abt, tbl[i].x_cnt);
        end

        // abort after 3 beats, si=0 ei=9
        i_fill = 1'b0; i_dir = 1'b0; i_si_ram = 6'd0; i_ei_ram = 6'd9;
        i_start = 1'b0; i_valid = 1'b0;
        tick();
        i_start = 1'b1;
        tick();
        chk("abt_launch_busy", 32'(o_busy), 1);
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_data = 8'(8'h40 + k);
            tick();
            chk_outs($sformatf("abt_beat%0d", k), 1, 6'(k), 8'(8'h40 + k), 1, 0, 0, 7'(k + 1));
        end
        i_abort = 1'b1; i_data = 8'h4F;
        @(negedge i_clk);
        chk("abt_ready", 32'(o_ready), 0);
        tick();
        chk_outs("abt_cyc", 0, 6'd2, 8'h00, 0, 0, 1, 3);
        i_abort = 1'b0;
        tick();
        chk_outs("abt_after", 0, 6'd2, 8'h00, 0, 0, 0, 3);
        // relaunch single word at 9
        i_start = 1'b0; i_si_ram = 6'd9; i_ei_ram = 6'd9; i_data = 8'h99;
        tick();
        i_start = 1'b1;
        tick();
        tick();
        chk_outs("relaunch", 1, 6'd9, 8'h99, 1, 1, 0, 1);
        i_valid = 1'b0;

        // second start edge mid-job ignored, si=0 ei=1
        i_start = 1'b0; i_si_ram = 6'd0; i_ei_ram = 6'd1;
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_start = 1'b1; i_si_ram = 6'd20; i_ei_ram = 6'd20;
        tick();
        i_valid = 1'b1; i_data = 8'h61;
        tick();
        chk_outs("mid_b0", 1, 6'd0, 8'h61, 1, 0, 0, 1);
        i_data = 8'h62;
        tick();
        chk_outs("mid_b1", 1, 6'd1, 8'h62, 1, 1, 0, 2);
        i_valid = 1'b0;
        tick();
        tick();
        chk("mid_no_relaunch", 32'(o_busy), 0);

        // maximum job: 64 fill words, 5 up to 4 with wrap
        begin
            int writes = 0;
            int done_at = -1;
            logic [5:0] last_addr = '0;
            i_start = 1'b0; i_fill = 1'b1; i_fill_data = 8'h77;
            i_si_ram = 6'd5; i_ei_ram = 6'd4;
            tick();
            i_start = 1'b1;
            tick();
            for (int c = 0; c < 80 && done_at < 0; c++) begin
                tick();
                if (o_we_ram) begin
                    writes++;
                    last_addr = o_addr_ram;
                end
                if (o_done) done_at = writes;
            end
            chk("max_done_at", 32'(done_at), 64);
            chk("max_writes", 32'(writes), 64);
            chk("max_last_addr", 32'(last_addr), 4);
            chk("max_count", 32'(o_count), 64);
        end

        // reset mid-job
        i_start = 1'b0; i_si_ram = 6'd0; i_ei_ram = 6'd20; i_fill_data = 8'h33;
        tick();
        i_start = 1'b1;
        tick();
        tick();
        tick();
        chk("rmid_we_before", 32'(o_we_ram), 1);
        #2;
        i_rst = 1'b1;
        #1;
        chk_outs("rmid", 0, 0, 8'h00, 0, 0, 0, 0);
        chk("rmid_ready", 32'(o_ready), 0);
        tick();
        chk_outs("rmid_hold", 0, 0, 8'h00, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ss_range_write_ctrl.md
# ss_range_write_ctrl

Parametrised BRAM range writer. On a start pulse it writes one word per accepted beat into the address window from a start index to an end index, inclusive. It supports ascending and descending traversal, modulo wrap-around, a constant-fill mode, abort, and a valid/ready source handshake. It sits between a data producer (sorter/compute stage) and a single-port BRAM write port, and replaces the fixed-increment, no-backpressure writer.

## Interface
- SIZE_ADDR, 6, BRAM address width; address arithmetic is modulo 2^SIZE_ADDR
- SIZE_DATA, 8, BRAM data width
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_start  in  1  level; a 0→1 transition launches a job
- i_abort  in  1  synchronous abort request
- i_dir  in  1  0 = ascending, 1 = descending; sampled at launch
- i_fill  in  1  1 = constant-fill mode; sampled at launch
- i_fill_data  in  SIZE_DATA  fill word; sampled at launch
- i_si_ram  in  SIZE_ADDR  first address; sampled at launch
- i_ei_ram  in  SIZE_ADDR  last address, inclusive; sampled at launch
- i_valid  in  1  source word valid
- i_data  in  SIZE_DATA  source word
- o_ready  out  1  block accepts a source word this cycle
- o_we_ram  out  1  BRAM write enable
- o_addr_ram  out  SIZE_ADDR  BRAM address
- o_data_ram  out  SIZE_DATA  BRAM write data
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle pulse: job completed
- o_aborted  out  1  one-cycle pulse: job aborted
- o_count  out  SIZE_ADDR+1  words written in current/last job

## Operation
- States:
  - IDLE: waits for launch.
  - RUN: writes words.
  - FINISH: one cycle; emits o_done.
- IDLE → RUN on a detected rising edge of i_start.
  - Latches i_si_ram, i_ei_ram, i_dir, i_fill, i_fill_data.
  - Sets cur_addr = si and clears o_count.
- i_start edges outside IDLE are ignored; they are not queued.
- Beat in RUN:
  - Stream mode: i_valid & o_ready.
  - Fill mode: every cycle; i_valid is ignored and o_ready = 0.
- On each beat, next cycle:
  - o_we_ram = 1, o_addr_ram = cur_addr.
  - o_data_ram = i_data, or the latched fill word in fill mode.
  - o_count += 1.
- After the beat, cur_addr advances by +1 (ascending) or −1 (descending), modulo 2^SIZE_ADDR.
- Wrap: job length = ((ei − si) mod 2^SIZE_ADDR) + 1 ascending, ((si − ei) mod 2^SIZE_ADDR) + 1 descending.
  - si == ei writes exactly one word.
  - The maximum job is 2^SIZE_ADDR words.
- RUN → FINISH on the beat where cur_addr == ei (latched).
- FINISH → IDLE unconditionally.
- o_ready = (state == RUN) & ~fill & ~i_abort. This is the only combinational output.
- With no beat, o_we_ram = 0, o_data_ram = 0, and o_addr_ram holds its last value.
- Abort:
  - i_abort in RUN → IDLE next cycle. No beat is taken that cycle.
  - o_aborted pulses, o_done stays low, o_count holds.
  - i_abort in IDLE or FINISH has no effect.
- Abort and final beat in the same cycle: abort wins and the beat is not taken.
- Reset mid-job: immediate return to IDLE; the partial job is discarded and no pulse is emitted.

## Timing
- Reset values:
  - o_we_ram, o_addr_ram, o_data_ram, o_busy, o_done, o_aborted, o_count = 0.
  - o_ready = 0; state = IDLE.
  - The edge-detect history register resets to 1, so i_start held high through reset does not launch a job.
- i_start rises at cycle T: edge registered at T+1, RUN at T+1, o_busy = 1 at T+1, first possible beat at T+1.
- Beat at cycle N → write visible on o_*_ram at N+1.
- Final beat at N:
  - Final write at N+1, with FINISH at N+1.
  - o_done = 1 at N+1 only, coincident with the final o_we_ram.
  - o_busy = 0 from N+2.
- Fill mode throughput is 1 word/cycle; stream mode is 1 word per handshake.
- Earliest relaunch: an i_start edge sampled at N+2.

## Structure
- Package ss_write_pkg holds:
  - the state enum (IDLE, RUN, FINISH);
  - the direction constants DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
- Sub-module ss_rise_detect: a registered rising-edge detector with active-high async reset, history register reset to 1.

## Test plan
- **Ascending stream:** SIZE_ADDR = 6, si = 4, ei = 7, i_valid always high, data 0xA0..0xA3 → writes (4,A0) (5,A1) (6,A2) (7,A3) on consecutive cycles; o_done with the last write; o_count = 4.
- **Wrap and descending:**
  - Ascending si = 62, ei = 1 → addresses 62, 63, 0, 1; o_count = 4.
  - Descending si = 1, ei = 62 → 1, 0, 63, 62.
- **Backpressure:** si = 0, ei = 2, i_valid toggles 1,0,0,1,1 → exactly 3 writes, each one cycle after its valid beat; no write in gap cycles.
- **Fill mode:** si = 10, ei = 10, fill = 0x5A → one write (10,5A); o_ready stays 0; o_done is the same cycle as the write.
- **Abort:** si = 0, ei = 9; assert i_abort after 3 beats → 3 writes only; o_aborted pulses once; o_done stays 0; o_count = 3; a new start then works normally.
- **Reset and ignored start:**
  - i_start held high through reset release → no job launches.
  - A second i_start edge mid-job is ignored.
  - i_rst asserted mid-job → all outputs 0 immediately.
